counter_bcd_ndigit: RTL and testbench

COUNTER_BCD_NDIGIT -- requirements
Module: counter_bcd_ndigit

---
 rtl/counter_bcd_ndigit_pkg.sv | 14 +
 rtl/counter_bcd_ndigit_if.sv | 26 ++
 rtl/counter_bcd_ndigit_bcd_digit_cell.sv | 38 +++
 rtl/counter_bcd_ndigit.sv | 87 ++++++++
 tb/tb_counter_bcd_ndigit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_bcd_ndigit_pkg.sv
// Shared types and limits for the N-digit BCD event counter.
package counter_bcd_ndigit_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX    = 4'd9;
  localparam int         MAX_DIGITS = 12;

  // An out-of-range code returns to zero, so a digit can never leave 0..9.
  function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
    return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/counter_bcd_ndigit_if.sv
// Control inputs and result outputs of the BCD counter, grouped as one bus.
interface counter_bcd_ndigit_if #(parameter int DIGITS = 8);

  logic                  enable_in;
  logic                  clear_in;
  logic                  latch_in;
  logic [4*DIGITS-1:0]   count_out;
  logic [4*DIGITS-1:0]   latched_out;
  logic                  overflow_out;
  logic                  latched_overflow_out;
  logic                  latched_valid_out;
  logic                  carry_out;

  modport master (
    output enable_in, clear_in, latch_in,
    input  count_out, latched_out, overflow_out,
           latched_overflow_out, latched_valid_out, carry_out
  );

  modport slave (
    input  enable_in, clear_in, latch_in,
    output count_out, latched_out, overflow_out,
           latched_overflow_out, latched_valid_out, carry_out
  );

endinterface

// File: rtl/counter_bcd_ndigit_bcd_digit_cell.sv
// One decimal digit of the cascade: increments on carry-in, passes carry on at 9.
module bcd_digit_cell
  import counter_bcd_ndigit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_in,
  input  logic       carry_in,
  output bcd_digit_t digit_out,
  output logic       is_max_out,
  output logic       carry_out
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clear_in) begin
      digit_d = '0;
    end else if (carry_in) begin
      digit_d = bcd_inc(digit_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_out  = digit_q;
  assign is_max_out = (digit_q == BCD_MAX);
  assign carry_out  = carry_in && is_max_out;

endmodule

// File: rtl/counter_bcd_ndigit.sv
// N-digit cascaded BCD counter with sticky overflow and a capture register.
module counter_bcd_ndigit
  import counter_bcd_ndigit_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int SATURATE = 0
)
(
  input  logic               clk_in,
  input  logic               reset_in,
  counter_bcd_ndigit_if.slave bus
);

  if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("counter_bcd_ndigit: DIGITS must be in 1..12");
  end

  logic [4*DIGITS-1:0] count;
  logic [DIGITS-1:0]   is_max;
  logic [DIGITS:0]     carry;
  logic                all_nines;
  logic                max_hit;

  logic                overflow_q, overflow_d;
  logic [4*DIGITS-1:0] latched_q, latched_d;
  logic                latched_ovf_q, latched_ovf_d;
  logic                latched_valid_q, latched_valid_d;

  assign all_nines = &is_max;

  // In saturating mode the chain is never started at all-nines, so the count holds.
  assign carry[0] = bus.enable_in && !bus.clear_in && !((SATURATE != 0) && all_nines);

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk        (clk_in),
      .rst        (reset_in),
      .clear_in   (bus.clear_in),
      .carry_in   (carry[k]),
      .digit_out  (count[4*k +: 4]),
      .is_max_out (is_max[k]),
      .carry_out  (carry[k+1])
    );
  end

  // Wrap mode sees the event as carry out of the top digit; saturate mode never ripples.
  assign max_hit = (SATURATE != 0) ? (bus.enable_in && !bus.clear_in && all_nines)
                                   : carry[DIGITS];

  always_comb begin
    overflow_d      = overflow_q;
    latched_d       = latched_q;
    latched_ovf_d   = latched_ovf_q;
    latched_valid_d = bus.latch_in;
    if (bus.clear_in) begin
      overflow_d = 1'b0;
    end else if (max_hit) begin
      overflow_d = 1'b1;
    end
    if (bus.latch_in) begin
      latched_d     = count;
      latched_ovf_d = overflow_q;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      overflow_q      <= 1'b0;
      latched_q       <= '0;
      latched_ovf_q   <= 1'b0;
      latched_valid_q <= 1'b0;
    end else begin
      overflow_q      <= overflow_d;
      latched_q       <= latched_d;
      latched_ovf_q   <= latched_ovf_d;
      latched_valid_q <= latched_valid_d;
    end
  end

  assign bus.count_out            = count;
  assign bus.latched_out          = latched_q;
  assign bus.overflow_out         = overflow_q;
  assign bus.latched_overflow_out = latched_ovf_q;
  assign bus.latched_valid_out    = latched_valid_q;
  assign bus.carry_out            = max_hit && !reset_in;

endmodule

// File: tb/tb_counter_bcd_ndigit.sv
// Bench for counter_bcd_ndigit: a wrapping and a saturating 4-digit instance share stimulus.
module tb_counter_bcd_ndigit;

  localparam int DIGITS  = 4;
  localparam int MAX_VAL = 9999;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic clear;
  logic latch;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  counter_bcd_ndigit_if #(.DIGITS(DIGITS)) bus0 ();
  counter_bcd_ndigit_if #(.DIGITS(DIGITS)) bus1 ();

  assign bus0.enable_in = enable;
  assign bus0.clear_in  = clear;
  assign bus0.latch_in  = latch;
  assign bus1.enable_in = enable;
  assign bus1.clear_in  = clear;
  assign bus1.latch_in  = latch;

  counter_bcd_ndigit #(.DIGITS(DIGITS), .SATURATE(0)) u_wrap (
    .clk_in   (clk),
    .reset_in (reset),
    .bus      (bus0)
  );

  counter_bcd_ndigit #(.DIGITS(DIGITS), .SATURATE(1)) u_sat (
    .clk_in   (clk),
    .reset_in (reset),
    .bus      (bus1)
  );

  // Reference model: decimal integers per instance, index 0 = wrap, 1 = saturate.
  int m_cnt    [2];
  bit m_ovf    [2];
  int m_lat    [2];
  bit m_latovf [2];
  bit m_valid  [2];

  typedef struct {
    logic        en;
    logic        clr;
    logic        lat;
    logic [15:0] exp_count;
    logic [15:0] exp_latched;
    logic        exp_valid;
  } vec_t;

  vec_t vectors [9];

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r = '0;
    int rem = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 0; m_ovf[s] = 0; m_lat[s] = 0; m_latovf[s] = 0; m_valid[s] = 0;
    end
  endtask

  task automatic model_step(input bit en, input bit clr, input bit lat);
    for (int s = 0; s < 2; s++) begin
      m_valid[s] = lat;
      if (lat) begin
        m_lat[s]    = m_cnt[s];
        m_latovf[s] = m_ovf[s];
      end
      if (clr) begin
        m_cnt[s] = 0;
        m_ovf[s] = 0;
      end else if (en) begin
        if (m_cnt[s] == MAX_VAL) begin
          m_ovf[s] = 1;
          m_cnt[s] = (s == 1) ? MAX_VAL : 0;
        end else begin
          m_cnt[s] = m_cnt[s] + 1;
        end
      end
    end
  endtask

  task automatic check1(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit clr, input bit lat);
    enable = en;
    clear  = clr;
    latch  = lat;
    @(posedge clk);
    model_step(en, clr, lat);
    #1;
  endtask

  task automatic checkOutput(input string name);
    check1({name, " wrap count"},   32'(bus0.count_out),            to_bcd(m_cnt[0]));
    check1({name, " wrap ovf"},     32'(bus0.overflow_out),         32'(m_ovf[0]));
    check1({name, " wrap latched"}, 32'(bus0.latched_out),          to_bcd(m_lat[0]));
    check1({name, " wrap latovf"},  32'(bus0.latched_overflow_out), 32'(m_latovf[0]));
    check1({name, " wrap valid"},   32'(bus0.latched_valid_out),    32'(m_valid[0]));
    check1({name, " sat count"},    32'(bus1.count_out),            to_bcd(m_cnt[1]));
    check1({name, " sat ovf"},      32'(bus1.overflow_out),         32'(m_ovf[1]));
    check1({name, " sat latched"},  32'(bus1.latched_out),          to_bcd(m_lat[1]));
    check1({name, " sat latovf"},   32'(bus1.latched_overflow_out), 32'(m_latovf[1]));
    check1({name, " sat valid"},    32'(bus1.latched_valid_out),    32'(m_valid[1]));
  endtask

  task automatic do_reset();
    enable = 0; clear = 0; latch = 0;
    reset  = 1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors[0] = '{1, 0, 0, 16'h0001, 16'h0000, 0};
    vectors[1] = '{1, 0, 0, 16'h0002, 16'h0000, 0};
    vectors[2] = '{0, 0, 1, 16'h0002, 16'h0002, 1};
    vectors[3] = '{1, 0, 1, 16'h0003, 16'h0002, 1};
    vectors[4] = '{1, 1, 1, 16'h0000, 16'h0003, 1};
    vectors[5] = '{0, 0, 0, 16'h0000, 16'h0003, 0};
    vectors[6] = '{1, 1, 0, 16'h0000, 16'h0003, 0};
    vectors[7] = '{1, 0, 0, 16'h0001, 16'h0003, 0};
    vectors[8] = '{0, 1, 0, 16'h0000, 16'h0003, 0};

    enable = 0; clear = 0; latch = 0;
    reset  = 1;
    model_reset();
    #3;
    checkOutput("reset");
    @(posedge clk);
    #1;
    reset = 0;

    foreach (vectors[i]) begin
      applyStimulus(vectors[i].en, vectors[i].clr, vectors[i].lat);
      check1($sformatf("vec%0d wrap count", i),   32'(bus0.count_out),         32'(vectors[i].exp_count));
      check1($sformatf("vec%0d sat count", i),    32'(bus1.count_out),         32'(vectors[i].exp_count));
      check1($sformatf("vec%0d latched", i),      32'(bus0.latched_out),       32'(vectors[i].exp_latched));
      check1($sformatf("vec%0d valid", i),        32'(bus0.latched_valid_out), 32'(vectors[i].exp_valid));
      checkOutput($sformatf("vec%0d model", i));
    end

    // Long count up to the all-nines boundary, then across it.
    do_reset();
    repeat (1234) applyStimulus(1, 0, 0);
    check1("count 1234 value", 32'(bus0.count_out), 32'h1234);
    check1("count 1234 ovf",   32'(bus0.overflow_out), 0);
    checkOutput("count 1234");
    repeat (MAX_VAL - 1234) applyStimulus(1, 0, 0);
    checkOutput("count 9999");
    enable = 1; clear = 1; latch = 0;
    #1;
    check1("carry blocked by clear wrap", 32'(bus0.carry_out), 0);
    check1("carry blocked by clear sat",  32'(bus1.carry_out), 0);
    clear = 0;
    #1;
    check1("carry at max wrap", 32'(bus0.carry_out), 1);
    check1("carry at max sat",  32'(bus1.carry_out), 1);
    applyStimulus(1, 0, 0);
    check1("wrap to zero",   32'(bus0.count_out),    32'h0000);
    check1("wrap ovf set",   32'(bus0.overflow_out), 1);
    check1("sat holds",      32'(bus1.count_out),    32'h9999);
    check1("carry after wrap", 32'(bus0.carry_out),  0);
    repeat (4) applyStimulus(1, 0, 0);
    check1("sat after 5",    32'(bus1.count_out),    32'h9999);
    check1("sat ovf sticky", 32'(bus1.overflow_out), 1);
    check1("wrap ovf sticky", 32'(bus0.overflow_out), 1);
    checkOutput("post overflow");
    applyStimulus(0, 0, 1);
    check1("latched ovf captured", 32'(bus0.latched_overflow_out), 1);
    applyStimulus(0, 1, 0);
    check1("latched ovf survives clear", 32'(bus1.latched_overflow_out), 1);
    check1("ovf cleared", 32'(bus1.overflow_out), 0);
    checkOutput("clear after overflow");

    // Gate-boundary restart: latch + clear + enable together.
    do_reset();
    repeat (57) applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 1);
    check1("gate latched", 32'(bus0.latched_out),       32'h0057);
    check1("gate count",   32'(bus0.count_out),         32'h0000);
    check1("gate valid",   32'(bus0.latched_valid_out), 1);
    applyStimulus(0, 0, 0);
    check1("gate valid drop", 32'(bus0.latched_valid_out), 0);
    checkOutput("gate");

    // Asynchronous reset between edges.
    do_reset();
    repeat (42) applyStimulus(1, 0, 0);
    latch  = 1;
    #2;
    reset = 1;
    model_reset();
    #1;
    checkOutput("async reset");
    @(posedge clk);
    #1;
    reset = 0;
    applyStimulus(1, 0, 0);
    check1("resume after reset", 32'(bus0.count_out), 32'h0001);
    checkOutput("resume");

    // Capture held across a clear.
    do_reset();
    repeat (10) applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 0);
    repeat (3) applyStimulus(1, 0, 0);
    check1("hold latched", 32'(bus0.latched_out),          32'h0010);
    check1("hold latovf",  32'(bus0.latched_overflow_out), 0);
    check1("hold count",   32'(bus0.count_out),            32'h0003);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0);
      checkOutput($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
